// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register.
// Captures EX-stage results and control for the MEM stage. Traps and ALU
// overflow squash side-effecting controls. The LL/SC link bit lives here too.
module ex_mem_reg (
    input  logic        clock,
    input  logic        reset,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        Trap,
    input  logic        TrapCond,
    input  logic        LLSC,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        MemHalf,
    input  logic        MemByte,
    input  logic        MemSignExtend,
    input  logic        RegWrite,
    input  logic        MemtoReg,
    input  logic [31:0] ALUResult,
    input  logic [31:0] ReadData2,
    input  logic [4:0]  RegDstOut,
    input  logic        ExcOv,
    input  logic        ClearLL,
    output logic        M_MemRead,
    output logic        M_MemWrite,
    output logic        M_MemHalf,
    output logic        M_MemByte,
    output logic        M_MemSignExtend,
    output logic        M_RegWrite,
    output logic        M_MemtoReg,
    output logic        M_LLSC,
    output logic [31:0] M_ALUResult,
    output logic [31:0] M_WriteData,
    output logic [4:0]  M_RegDst,
    output logic        M_ExcTrap,
    output logic        M_ExcOv,
    output logic        M_LLbit
);

    logic trapTaken;
    logic excAny;

    assign trapTaken = Trap & (ALUResult[0] == TrapCond);
    assign excAny    = trapTaken | ExcOv;

    // Pipeline fields: reset/flush load a bubble, stall holds, else capture.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            M_MemRead       <= 1'b0;
            M_MemWrite      <= 1'b0;
            M_MemHalf       <= 1'b0;
            M_MemByte       <= 1'b0;
            M_MemSignExtend <= 1'b0;
            M_RegWrite      <= 1'b0;
            M_MemtoReg      <= 1'b0;
            M_LLSC          <= 1'b0;
            M_ALUResult     <= 32'd0;
            M_WriteData     <= 32'd0;
            M_RegDst        <= 5'd0;
            M_ExcTrap       <= 1'b0;
            M_ExcOv         <= 1'b0;
        end else if (Flush) begin
            M_MemRead       <= 1'b0;
            M_MemWrite      <= 1'b0;
            M_MemHalf       <= 1'b0;
            M_MemByte       <= 1'b0;
            M_MemSignExtend <= 1'b0;
            M_RegWrite      <= 1'b0;
            M_MemtoReg      <= 1'b0;
            M_LLSC          <= 1'b0;
            M_ALUResult     <= 32'd0;
            M_WriteData     <= 32'd0;
            M_RegDst        <= 5'd0;
            M_ExcTrap       <= 1'b0;
            M_ExcOv         <= 1'b0;
        end else if (!Stall) begin
            M_MemRead       <= MemRead  & ~excAny;
            M_MemWrite      <= MemWrite & ~excAny;
            M_MemHalf       <= MemHalf;
            M_MemByte       <= MemByte;
            M_MemSignExtend <= MemSignExtend;
            M_RegWrite      <= RegWrite & ~excAny;
            M_MemtoReg      <= MemtoReg;
            M_LLSC          <= LLSC     & ~excAny;
            M_ALUResult     <= ALUResult;
            M_WriteData     <= ReadData2;
            M_RegDst        <= RegDstOut;
            M_ExcTrap       <= trapTaken;
            M_ExcOv         <= ExcOv;
        end
    end

    // Link bit: ClearLL beats everything but reset; only a clean LL/SC load moves it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            M_LLbit <= 1'b0;
        end else if (ClearLL) begin
            M_LLbit <= 1'b0;
        end else if (!Flush && !Stall && !excAny) begin
            if (LLSC && MemRead) begin
                M_LLbit <= 1'b1;
            end else if (LLSC && MemWrite) begin
                M_LLbit <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed + randomized bench for ex_mem_reg with a queue-based scoreboard.
module tb_ex_mem_reg;

    logic        clock, reset, Stall, Flush, Trap, TrapCond, LLSC;
    logic        MemRead, MemWrite, MemHalf, MemByte, MemSignExtend;
    logic        RegWrite, MemtoReg, ExcOv, ClearLL;
    logic [31:0] ALUResult, ReadData2;
    logic [4:0]  RegDstOut;
    logic        M_MemRead, M_MemWrite, M_MemHalf, M_MemByte, M_MemSignExtend;
    logic        M_RegWrite, M_MemtoReg, M_LLSC, M_ExcTrap, M_ExcOv, M_LLbit;
    logic [31:0] M_ALUResult, M_WriteData;
    logic [4:0]  M_RegDst;

    typedef struct packed {
        logic        memRead;
        logic        memWrite;
        logic        memHalf;
        logic        memByte;
        logic        memSignExtend;
        logic        regWrite;
        logic        memtoReg;
        logic        llsc;
        logic [31:0] aluResult;
        logic [31:0] writeData;
        logic [4:0]  regDst;
        logic        excTrap;
        logic        excOv;
        logic        llBit;
    } outs_t;

    outs_t mdl;
    outs_t expQ[$];
    int    nVec = 0;
    int    nErr = 0;

    ex_mem_reg dut (
        .clock(clock), .reset(reset), .Stall(Stall), .Flush(Flush),
        .Trap(Trap), .TrapCond(TrapCond), .LLSC(LLSC),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemHalf(MemHalf),
        .MemByte(MemByte), .MemSignExtend(MemSignExtend),
        .RegWrite(RegWrite), .MemtoReg(MemtoReg),
        .ALUResult(ALUResult), .ReadData2(ReadData2), .RegDstOut(RegDstOut),
        .ExcOv(ExcOv), .ClearLL(ClearLL),
        .M_MemRead(M_MemRead), .M_MemWrite(M_MemWrite), .M_MemHalf(M_MemHalf),
        .M_MemByte(M_MemByte), .M_MemSignExtend(M_MemSignExtend),
        .M_RegWrite(M_RegWrite), .M_MemtoReg(M_MemtoReg), .M_LLSC(M_LLSC),
        .M_ALUResult(M_ALUResult), .M_WriteData(M_WriteData), .M_RegDst(M_RegDst),
        .M_ExcTrap(M_ExcTrap), .M_ExcOv(M_ExcOv), .M_LLbit(M_LLbit)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic outs_t dutOuts();
        outs_t o;
        o = '{M_MemRead, M_MemWrite, M_MemHalf, M_MemByte, M_MemSignExtend,
              M_RegWrite, M_MemtoReg, M_LLSC, M_ALUResult, M_WriteData,
              M_RegDst, M_ExcTrap, M_ExcOv, M_LLbit};
        return o;
    endfunction

    // Reference behaviour written straight from the requirement list.
    function automatic outs_t modelNext(outs_t cur);
        outs_t n;
        logic  tt, ex;
        tt = Trap && (ALUResult[0] == TrapCond);
        ex = tt || ExcOv;
        n  = cur;
        if (Flush) begin
            n = '0;
            n.llBit = cur.llBit;
        end else if (!Stall) begin
            n.memRead       = MemRead && !ex;
            n.memWrite      = MemWrite && !ex;
            n.memHalf       = MemHalf;
            n.memByte       = MemByte;
            n.memSignExtend = MemSignExtend;
            n.regWrite      = RegWrite && !ex;
            n.memtoReg      = MemtoReg;
            n.llsc          = LLSC && !ex;
            n.aluResult     = ALUResult;
            n.writeData     = ReadData2;
            n.regDst        = RegDstOut;
            n.excTrap       = tt;
            n.excOv         = ExcOv;
            if (!ex && LLSC && MemRead)       n.llBit = 1'b1;
            else if (!ex && LLSC && MemWrite) n.llBit = 1'b0;
        end
        if (ClearLL) n.llBit = 1'b0;
        return n;
    endfunction

    task automatic clearIns();
        Stall = 0; Flush = 0; Trap = 0; TrapCond = 0; LLSC = 0;
        MemRead = 0; MemWrite = 0; MemHalf = 0; MemByte = 0; MemSignExtend = 0;
        RegWrite = 0; MemtoReg = 0; ExcOv = 0; ClearLL = 0;
        ALUResult = '0; ReadData2 = '0; RegDstOut = '0;
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        nVec++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic checkOuts(input string tag, input outs_t exp);
        outs_t obs;
        obs = dutOuts();
        nVec++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: push the predicted result, take the edge, pop and compare.
    task automatic cycle(input string tag);
        outs_t e;
        e   = modelNext(mdl);
        mdl = e;
        expQ.push_back(e);
        @(posedge clock);
        #1;
        if (expQ.size() == 0) begin
            nVec++; nErr++;
            $error("FAIL %s observed=empty expected=entry", tag);
        end else begin
            checkOuts(tag, expQ.pop_front());
        end
    endtask

    initial begin
        logic [31:0] r;
        clearIns();
        reset = 1'b1;
        mdl   = '0;
        #1;
        checkOuts("reset_state", '0);
        #6 reset = 1'b0;   // between edges

        // Basic load
        ALUResult = 32'h0000_00FF; RegWrite = 1; RegDstOut = 5'd5;
        cycle("load_ff");
        checkBit("load_ff_regwrite", M_RegWrite, 1'b1);
        nVec++;
        assert (M_ALUResult === 32'h0000_00FF && M_RegDst === 5'd5) else begin
            nErr++; $error("FAIL load_ff_data observed=%h/%0d expected=ff/5", M_ALUResult, M_RegDst);
        end

        // Stall three cycles with changing inputs, then Flush+Stall
        clearIns();
        ClearLL = 1; ALUResult = 32'h1234_5678; ReadData2 = 32'hCAFE_F00D;
        RegDstOut = 5'd17; MemWrite = 1; MemHalf = 1; MemtoReg = 1;
        cycle("load_prestall");
        ClearLL = 0; Stall = 1;
        for (int i = 0; i < 3; i++) begin
            r = $urandom;
            ALUResult = r; ReadData2 = ~r; RegDstOut = r[4:0];
            RegWrite = r[5]; MemRead = r[6]; MemByte = r[7];
            cycle("stall_hold");
        end
        checkBit("stall_writedata", M_WriteData == 32'hCAFE_F00D, 1'b1);
        Flush = 1;
        cycle("flush_stall");
        checkOuts("flush_stall_zero", '0);

        // Trap taken / not taken
        clearIns();
        Trap = 1; TrapCond = 1; ALUResult = 32'd1; RegWrite = 1;
        cycle("trap_taken");
        checkBit("trap_taken_exc", M_ExcTrap, 1'b1);
        checkBit("trap_taken_rw", M_RegWrite, 1'b0);
        ALUResult = 32'd0;
        cycle("trap_not_taken");
        checkBit("trap_nt_exc", M_ExcTrap, 1'b0);
        checkBit("trap_nt_rw", M_RegWrite, 1'b1);

        // Overflow squashes a store
        clearIns();
        ExcOv = 1; MemWrite = 1; ALUResult = 32'hDEAD_BEEF;
        cycle("ovf_store");
        checkBit("ovf_memwrite", M_MemWrite, 1'b0);

        // LL, nop, SC
        clearIns();
        LLSC = 1; MemRead = 1; RegWrite = 1; MemtoReg = 1;
        cycle("ll");
        checkBit("ll_set", M_LLbit, 1'b1);
        clearIns();
        cycle("nop");
        checkBit("ll_hold_before_sc", M_LLbit, 1'b1);
        LLSC = 1; MemWrite = 1;
        cycle("sc");
        checkBit("sc_clear", M_LLbit, 1'b0);
        clearIns();
        LLSC = 1; MemRead = 1; ClearLL = 1;
        cycle("ll_with_clearll");
        checkBit("clearll_wins", M_LLbit, 1'b0);

        // Flushed/excepted LL leave link alone; ClearLL during stall clears
        ClearLL = 0; Flush = 1;
        cycle("ll_flushed");
        Flush = 0; ExcOv = 1;
        cycle("ll_excepted");
        checkBit("ll_exc_nolink", M_LLbit, 1'b0);
        ExcOv = 0;
        cycle("ll_again");
        Flush = 1; LLSC = 1; MemWrite = 1; MemRead = 0;
        cycle("sc_flushed");
        checkBit("sc_flushed_keeps", M_LLbit, 1'b1);
        Flush = 0; Stall = 1; ClearLL = 1;
        cycle("clearll_stall");

        // Randomized mix
        for (int i = 0; i < 40; i++) begin
            r = $urandom;
            Stall = (r[3:0] == 4'd0); Flush = (r[7:4] == 4'd0);
            ClearLL = (r[11:8] == 4'd0); Trap = r[12]; TrapCond = r[13];
            LLSC = r[14]; MemRead = r[15]; MemWrite = r[16]; MemHalf = r[17];
            MemByte = r[18]; MemSignExtend = r[19]; RegWrite = r[20];
            MemtoReg = r[21]; ExcOv = (r[24:22] == 3'd0);
            ALUResult = $urandom; ReadData2 = $urandom; RegDstOut = r[31:27];
            cycle("random");
        end

        // Async reset between edges, then release mid-stall
        clearIns();
        LLSC = 1; MemRead = 1; RegWrite = 1;
        cycle("ll_before_reset");
        #2 reset = 1'b1;
        #1;
        checkBit("async_rst_regwrite", M_RegWrite, 1'b0);
        checkBit("async_rst_llbit", M_LLbit, 1'b0);
        mdl = '0;
        Stall = 1;
        #7 reset = 1'b0;
        cycle("stall_after_reset");
        cycle("stall_after_reset2");
        checkOuts("bubble_after_reset", '0);
        Stall = 0;
        cycle("first_load_after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule

// File: doc/ex_mem_reg.md
EX_MEM_REG -- requirements
Module: ex_mem_reg

Interface
REQ-001 SHALL have ports: clock  in  1  pipeline clock; reset  in  1  asynchronous, active-high reset.
REQ-002 SHALL have: Stall  in  1  hold all registered state; Flush  in  1  load a bubble.
REQ-003 SHALL have EX-side control inputs, each 1 bit: Trap, TrapCond, LLSC, MemRead, MemWrite, MemHalf, MemByte, MemSignExtend, RegWrite, MemtoReg.
REQ-004 SHALL have EX-side data inputs: ALUResult 32, ReadData2 32, RegDstOut 5, ExcOv 1 (ALU overflow from this instruction).
REQ-005 SHALL have ClearLL  in  1: exception/ERET commit, clears the link bit.
REQ-006 SHALL have registered outputs M_MemRead, M_MemWrite, M_MemHalf, M_MemByte, M_MemSignExtend, M_RegWrite, M_MemtoReg, M_LLSC (1 bit each), M_ALUResult 32, M_WriteData 32, M_RegDst 5.
REQ-007 SHALL have registered outputs M_ExcTrap 1, M_ExcOv 1, M_LLbit 1.

Function
REQ-008 SHALL update on the rising edge of clock, with priority reset > Flush > Stall > load.
REQ-009 Load SHALL capture all inputs into the corresponding M_* outputs with 1-cycle latency (ReadData2 -> M_WriteData, RegDstOut -> M_RegDst).
REQ-010 SHALL compute TrapTaken = Trap & (ALUResult[0] == TrapCond), combinationally from the current inputs.
REQ-011 On load, M_ExcTrap SHALL be set to TrapTaken and M_ExcOv to ExcOv.
REQ-012 On load with TrapTaken or ExcOv, SHALL force M_RegWrite, M_MemRead, M_MemWrite and M_LLSC to 0; data fields are captured unchanged.
REQ-013 Flush SHALL set every control output, exception flag, M_ALUResult, M_WriteData and M_RegDst to 0.
REQ-014 Stall SHALL hold every M_* output, including M_LLbit, unchanged.
REQ-015 Flush and Stall asserted together SHALL behave as Flush.
REQ-016 Link bit, a single state bit, SHALL be driven on M_LLbit.
REQ-017 Link bit set condition: load of an LL (LLSC & MemRead) with no exception.
REQ-018 Link bit clear condition: load of an SC (LLSC & MemWrite) with no exception.
REQ-019 ClearLL SHALL clear the link bit on any edge regardless of Stall, Flush, or a simultaneous LL load (ClearLL wins).
REQ-020 A flushed or excepted LL/SC SHALL leave the link bit unchanged (absent ClearLL).
REQ-021 M_LLbit SHALL reflect the link bit value after the edge, so an SC in MEM sees the value set by any earlier LL.
REQ-022 SHALL contain no combinational path from any input to any output.

Reset
REQ-023 While reset=1, all M_* outputs and the link bit SHALL be 0, asynchronously and independent of clock.
REQ-024 Reset deasserted mid-stall SHALL resume as a bubble, with all outputs 0 until the first load.

Verification
REQ-025 Load ALUResult=0x0000_00FF, RegWrite=1, RegDstOut=5 -> next cycle M_ALUResult=0xFF, M_RegWrite=1, M_RegDst=5, flags 0.
REQ-026 Stall=1 for 3 cycles with changing inputs -> outputs frozen at their prior values; Flush=1 with Stall=1 -> all outputs 0.
REQ-027 Trap=1, TrapCond=1, ALUResult=1, RegWrite=1 -> M_ExcTrap=1, M_RegWrite=0; ALUResult=0 -> M_ExcTrap=0, M_RegWrite=1.
REQ-028 ExcOv=1 with MemWrite=1 -> M_ExcOv=1, M_MemWrite=0, M_ALUResult captured.
REQ-029 Sequence LL, nop, SC -> M_LLbit=1 after the LL, stays 1 at the SC edge, 0 after the SC; LL with ClearLL=1 on the same edge -> M_LLbit=0.
REQ-030 Assert reset asynchronously between edges with M_RegWrite=1, M_LLbit=1 -> both 0 immediately, before the next clock edge.
